// File: rtl/alu_console.sv
// alu_console: operator console for the lab ALU.
// Operand entry from switches, opcode latch, result capture, button debounce
// and a paged 16-bit display window over the selected register.
module alu_console #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DB_CNT   = 1_000_000,
  parameter logic [31:0] OP1_INIT = 32'h1122,
  parameter logic [31:0] OP2_INIT = 32'h3344
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       button,
  input  logic [6:0]       switch,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zf,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic [2:0]       alu_ctrl,
  output logic [15:0]      disp_num,
  output logic             o_zf,
  output logic             busy
);

  localparam int unsigned PAGES = WIDTH / 16;
  localparam int unsigned PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned CW    = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CW-1:0]    DB_MAX    = CW'(DB_CNT - 1);
  localparam logic [PW-1:0]    PAGE_LAST = PW'(PAGES - 1);
  localparam logic [WIDTH-1:0] OP1_RST   = WIDTH'(OP1_INIT);
  localparam logic [WIDTH-1:0] OP2_RST   = WIDTH'(OP2_INIT);

  localparam logic [1:0] TGT_OP1 = 2'b00;
  localparam logic [1:0] TGT_OP2 = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Debounce: [0]=ENTER, [1]=EXEC
  // ---------------------------------------------------------------------------
  logic [1:0]         sync1_q, sync2_q, prev_q;
  logic [1:0]         level_q, level_d;
  logic [1:0]         pulse_q, pulse_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;

  // Stability counter per button; level follows input once stable long enough
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != prev_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != DB_MAX) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      if (cnt_q[i] == DB_MAX) begin
        level_d[i] = prev_q[i];
      end
    end
    pulse_d = level_d & ~level_q;
  end

  // Synchroniser, counters, debounced levels and edge pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Console registers and execute FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             zf_q, zf_d;
  logic [PW-1:0]    page_q, page_d;
  logic             busy_q, busy_d;
  logic [15:0]      disp_q, disp_d;
  logic [WIDTH-1:0] sel_c;

  logic       enter_p, exec_p, view_mode;
  logic [3:0] nibble;
  logic [1:0] target;

  assign enter_p   = pulse_q[0];
  assign exec_p    = pulse_q[1];
  assign view_mode = switch[6];
  assign nibble    = switch[5:2];
  assign target    = switch[1:0];

  // Next-state and register updates; ENTER wins over a simultaneous EXEC
  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    ctrl_d   = ctrl_q;
    zf_d     = zf_q;
    page_d   = page_q;

    case (state_q)
      S_IDLE: begin
        if (!view_mode) begin
          if (enter_p) begin
            if (target == TGT_OP1) begin
              op1_d = {op1_q[WIDTH-5:0], nibble};
            end else if (target == TGT_OP2) begin
              op2_d = {op2_q[WIDTH-5:0], nibble};
            end
          end else if (exec_p) begin
            ctrl_d  = switch[4:2];
            state_d = S_WAIT;
          end
        end else begin
          if (enter_p) begin
            page_d = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
          end else if (exec_p) begin
            if (target == TGT_OP1) begin
              op1_d = '0;
            end else if (target == TGT_OP2) begin
              op2_d = '0;
            end else begin
              result_d = '0;
              zf_d     = 1'b0;
            end
          end
        end
      end
      S_WAIT: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        result_d = alu_result;
        zf_d     = alu_zf;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Display window over the currently targeted register
  always_comb begin
    case (target)
      TGT_OP1: sel_c = op1_q;
      TGT_OP2: sel_c = op2_q;
      default: sel_c = result_q;
    endcase
    disp_d = sel_c[{page_q, 4'b0000} +: 16];
  end

  // Console state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op1_q    <= OP1_RST;
      op2_q    <= OP2_RST;
      result_q <= '0;
      ctrl_q   <= '0;
      zf_q     <= 1'b0;
      page_q   <= '0;
      busy_q   <= 1'b0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
      ctrl_q   <= ctrl_d;
      zf_q     <= zf_d;
      page_q   <= page_d;
      busy_q   <= busy_d;
      disp_q   <= disp_d;
    end
  end

  assign op1      = op1_q;
  assign op2      = op2_q;
  assign alu_ctrl = ctrl_q;
  assign o_zf     = zf_q;
  assign busy     = busy_q;
  assign disp_num = disp_q;

endmodule

// File: tb/tb_alu_console.sv
// Directed bench for alu_console (WIDTH=32, DB_CNT=4).
module tb_alu_console;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   button;
  logic [6:0]   switch;
  logic [W-1:0] alu_result;
  logic         alu_zf;
  logic [W-1:0] op1, op2;
  logic [2:0]   alu_ctrl;
  logic [15:0]  disp_num;
  logic         o_zf;
  logic         busy;

  int vectors = 0;
  int errors  = 0;

  alu_console #(
    .WIDTH(W),
    .DB_CNT(4),
    .OP1_INIT(32'h1122),
    .OP2_INIT(32'h3344)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .switch(switch),
    .alu_result(alu_result),
    .alu_zf(alu_zf),
    .op1(op1),
    .op2(op2),
    .alu_ctrl(alu_ctrl),
    .disp_num(disp_num),
    .o_zf(o_zf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a button pattern, release, then let the debouncer settle
  task automatic press(input logic [1:0] b, input int hold);
    button = b;
    tick(hold);
    button = 2'b00;
    tick(14);
  endtask

  task automatic wait_busy(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      if (busy) seen = 1'b1;
    end
  endtask

  function automatic logic [6:0] sw(input logic mode, input logic [3:0] nib, input logic [1:0] tgt);
    return {mode, nib, tgt};
  endfunction

  initial begin
    bit seen;
    logic [3:0] nibs [8];

    rst        = 1'b1;
    button     = 2'b00;
    switch     = sw(1'b0, 4'h0, 2'b00);
    alu_result = '0;
    alu_zf     = 1'b0;

    // 1 Reset
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset_op1", op1, 32'h0000_1122);
    check("reset_op2", op2, 32'h0000_3344);
    check("reset_disp", 32'(disp_num), 32'h1122);
    check("reset_busy", 32'(busy), 0);
    check("reset_ctrl", 32'(alu_ctrl), 0);
    check("reset_zf", 32'(o_zf), 0);

    // 2 Bounce: chatter then a long hold -> one shift of nibble F
    switch = sw(1'b0, 4'hF, 2'b00);
    for (int k = 0; k < 2; k++) begin
      button = 2'b01; tick(2);
      button = 2'b00; tick(2);
    end
    button = 2'b01;
    tick(8);
    button = 2'b00;
    tick(14);
    check("bounce_one_shift", op1, 32'h0001_122F);
    press(2'b01, 3);
    check("short_press_ignored", op1, 32'h0001_122F);
    check("bounce_disp", 32'(disp_num), 32'h122F);

    // Reset again to restore operands
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    check("rereset_op1", op1, 32'h0000_1122);

    // 3 Entry A..E into op1
    for (int n = 10; n <= 14; n++) begin
      switch = sw(1'b0, 4'(n), 2'b00);
      press(2'b01, 8);
    end
    check("entry_op1", op1, 32'h122A_BCDE);
    check("entry_disp", 32'(disp_num), 32'hBCDE);

    // 4 Execute with opcode 010; ENTER lands during busy and is dropped
    alu_result = 32'h0000_0000;
    alu_zf     = 1'b1;
    switch     = sw(1'b0, 4'h2, 2'b00);
    seen       = 1'b0;
    button     = 2'b10;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (i == 1) button = 2'b11;
      tick(1);
      if (busy) seen = 1'b1;
    end
    check("exec1_busy_seen", 32'(seen), 1);
    check("exec1_ctrl", 32'(alu_ctrl), 2);
    switch = sw(1'b0, 4'h7, 2'b00);
    tick(1);
    check("exec1_busy_2nd", 32'(busy), 1);
    tick(1);
    check("exec1_busy_done", 32'(busy), 0);
    check("exec1_zf", 32'(o_zf), 1);
    check("exec1_ctrl_frozen", 32'(alu_ctrl), 2);
    button = 2'b00;
    tick(14);
    check("exec1_enter_dropped", op1, 32'h122A_BCDE);
    switch = sw(1'b1, 4'h0, 2'b10);
    tick(2);
    check("exec1_result_disp", 32'(disp_num), 32'h0000);

    // View-mode EXEC on result clears result and zero flag
    press(2'b10, 8);
    check("view_clear_zf", 32'(o_zf), 0);
    check("view_clear_busy", 32'(busy), 0);

    // Second execute with a nonzero result
    alu_result = 32'hCAFE_BABE;
    alu_zf     = 1'b1;
    switch     = sw(1'b0, 4'h5, 2'b10);
    button     = 2'b10;
    wait_busy(seen);
    check("exec2_busy_seen", 32'(seen), 1);
    tick(2);
    check("exec2_busy_done", 32'(busy), 0);
    check("exec2_ctrl", 32'(alu_ctrl), 5);
    check("exec2_zf", 32'(o_zf), 1);
    button = 2'b00;
    tick(14);
    switch = sw(1'b1, 4'h0, 2'b10);
    tick(2);
    check("exec2_disp_p0", 32'(disp_num), 32'hBABE);
    press(2'b01, 8);
    check("exec2_disp_p1", 32'(disp_num), 32'hCAFE);
    press(2'b01, 8);
    check("exec2_disp_wrap", 32'(disp_num), 32'hBABE);

    // 5 Paging over op2 = DEAD3344
    nibs = '{4'hD, 4'hE, 4'hA, 4'hD, 4'h3, 4'h3, 4'h4, 4'h4};
    for (int n = 0; n < 8; n++) begin
      switch = sw(1'b0, nibs[n], 2'b01);
      press(2'b01, 8);
    end
    check("page_op2", op2, 32'hDEAD_3344);
    switch = sw(1'b1, 4'h0, 2'b01);
    tick(2);
    check("page_p0", 32'(disp_num), 32'h3344);
    press(2'b01, 8);
    check("page_p1", 32'(disp_num), 32'hDEAD);
    press(2'b01, 8);
    check("page_wrap", 32'(disp_num), 32'h3344);
    press(2'b10, 8);
    check("view_clear_op2", op2, 32'h0000_0000);

    // 6 Abort: reset during WAIT
    alu_result = 32'h55AA_55AA;
    alu_zf     = 1'b1;
    switch     = sw(1'b0, 4'h1, 2'b10);
    button     = 2'b10;
    wait_busy(seen);
    check("abort_busy_seen", 32'(seen), 1);
    rst = 1'b1;
    #1;
    check("abort_busy_now", 32'(busy), 0);
    check("abort_zf_now", 32'(o_zf), 0);
    check("abort_disp_now", 32'(disp_num), 32'h0000);
    button = 2'b00;
    tick(2);
    rst = 1'b0;
    tick(12);
    check("abort_no_capture", 32'(disp_num), 32'h0000);
    check("abort_busy_later", 32'(busy), 0);
    check("abort_zf_later", 32'(o_zf), 0);
    check("abort_ctrl", 32'(alu_ctrl), 0);
    check("abort_op1", op1, 32'h0000_1122);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
